// File: rtl/input_port_buffer.sv
// input_port_buffer: per-port router input FIFO with packet request/drain FSM
module input_port_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            flit_id,
  output logic [11:0]           length,
  output logic                  req,
  output logic [ADDR_W:0]       count,
  output logic                  err_drop
);
  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [11:0]           length_q, length_d;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            head_id;
  logic                  empty, push, pop, hdr_at_head;
  assign head        = mem_q[rd_ptr_q];
  assign head_id     = head[DATA_WIDTH-1 -: 3];
  assign empty       = count_q == '0;
  assign hdr_at_head = state_q == IDLE && !empty && head_id == 3'b001;
  assign in_ready    = rst && count_q != (ADDR_W+1)'(DEPTH);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid || err_drop;
  assign out_data    = head;
  assign flit_id     = empty ? 3'b000 : head_id;
  assign length      = hdr_at_head ? head[11:0] : length_q;
  assign req         = state_q != IDLE;
  assign count       = count_q;
  // Packet FSM: accept header, request, drain on grant until tail; discard orphans
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    out_valid = 1'b0;
    err_drop  = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        if (head_id == 3'b001) begin
          state_d  = WAIT;
          length_d = head[11:0];
        end else err_drop = 1'b1;
      end
      WAIT: state_d = grant ? XFER : WAIT;
      XFER: if (grant && !empty) begin
        out_valid = 1'b1;
        state_d   = head_id == 3'b100 ? IDLE : XFER;
      end
      default: state_d = IDLE;
    endcase
  end
  // FIFO storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end
  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      length_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed stimulus with a queue-based packet model checked every cycle
module tb_input_port_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        grant = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        req;
  logic [3:0]  count;
  logic        err_drop;
  int          errs = 0;
  int          checks = 0;
  logic [31:0] ov_log [$];
  logic [31:0] mq [$];
  int          ph = 0;
  logic [11:0] mlen = '0;

  input_port_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .grant(grant), .out_valid(out_valid), .out_data(out_data), .flit_id(flit_id),
    .length(length), .req(req), .count(count), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] fl(input logic [2:0] id, input int p);
    return {id, 29'(p)};
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d, input logic g);
    in_valid = v;
    in_data  = d;
    grant    = g;
    @(posedge clk);
    #1;
  endtask

  // Model: FIFO as a queue; ph 0 = no packet, 1 = header seen awaiting grant, 2 = granted
  initial begin
    logic        emp, e_ov, e_drop, e_rdy, do_push;
    logic [31:0] hd, pd;
    logic [2:0]  id;
    logic [11:0] e_len, n_len;
    int          n_ph;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq.delete();
        ph = 0;
        mlen = '0;
      end
      emp    = mq.size() == 0;
      hd     = emp ? 32'h0 : mq[0];
      id     = hd[31:29];
      e_rdy  = rst && mq.size() < 8;
      e_drop = ph == 0 && !emp && id != 3'b001;
      e_ov   = ph == 2 && grant && !emp;
      e_len  = (ph == 0 && !emp && id == 3'b001) ? hd[11:0] : mlen;
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("req", 32'(req), 32'(ph != 0));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("err_drop", 32'(err_drop), 32'(e_drop));
      chk("flit_id", 32'(flit_id), 32'(emp ? 3'b000 : id));
      chk("length", 32'(length), 32'(e_len));
      if (!emp) chk("out_data", out_data, hd);
      if (out_valid) ov_log.push_back(out_data);
      do_push = in_valid && e_rdy;
      pd      = in_data;
      n_ph    = ph;
      n_len   = mlen;
      if (ph == 0 && !emp && id == 3'b001) begin
        n_ph  = 1;
        n_len = hd[11:0];
      end
      if (ph == 1 && grant) n_ph = 2;
      if (e_ov && id == 3'b100) n_ph = 0;
      @(posedge clk);
      if (rst) begin
        if (e_ov || e_drop) void'(mq.pop_front());
        if (do_push) mq.push_back(pd);
        ph   = n_ph;
        mlen = n_len;
      end
    end
  end

  initial begin
    logic [31:0] exp8 [8];
    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("t1_rdy_in_reset", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_req", 32'(req), 32'd0);
    chk("t1_rdy", 32'(in_ready), 32'd1);
    chk("t1_fid", 32'(flit_id), 32'd0);
    chk("t1_len", 32'(length), 32'd0);
    cyc(0, '0, 0);
    // T2 single packet with grant from cycle after req
    ov_log.delete();
    cyc(1, fl(3'b001, 3), 0);
    chk("t2_req0", 32'(req), 32'd0);
    chk("t2_len_comb", 32'(length), 32'd3);
    cyc(1, fl(3'b010, 1), 0);
    chk("t2_req1", 32'(req), 32'd1);
    cyc(1, fl(3'b010, 2), 1);
    cyc(1, fl(3'b100, 9), 1);
    repeat (3) cyc(0, '0, 1);
    chk("t2_req_fall", 32'(req), 32'd0);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_len", 32'(length), 32'd3);
    chk("t2_nout", 32'(ov_log.size()), 32'd4);
    if (ov_log.size() == 4) begin
      chk("t2_o0", ov_log[0], 32'h2000_0003);
      chk("t2_o1", ov_log[1], 32'h4000_0001);
      chk("t2_o2", ov_log[2], 32'h4000_0002);
      chk("t2_o3", ov_log[3], 32'h8000_0009);
    end
    // T3 fill to full, then drain with push attempted throughout
    ov_log.delete();
    exp8[0] = fl(3'b001, 7);
    for (int i = 1; i < 7; i++) exp8[i] = fl(3'b010, i);
    exp8[7] = fl(3'b100, 7);
    for (int i = 0; i < 8; i++) cyc(1, exp8[i], 0);
    chk("t3_full", 32'(count), 32'd8);
    chk("t3_rdy", 32'(in_ready), 32'd0);
    chk("t3_len", 32'(length), 32'd7);
    cyc(1, fl(3'b010, 99), 1);
    chk("t3_wait_to_xfer", 32'(count), 32'd8);
    cyc(1, fl(3'b010, 99), 1);
    chk("t3_pop_only", 32'(count), 32'd7);
    cyc(1, fl(3'b010, 99), 1);
    chk("t3_push_pop", 32'(count), 32'd7);
    repeat (8) cyc(0, '0, 1);
    chk("t3_empty", 32'(count), 32'd0);
    chk("t3_nout", 32'(ov_log.size()), 32'd8);
    if (ov_log.size() == 8) for (int i = 0; i < 8; i++) chk("t3_order", ov_log[i], exp8[i]);
    // T4 orphan body in idle
    cyc(1, fl(3'b010, 5), 0);
    chk("t4_drop", 32'(err_drop), 32'd1);
    cyc(0, '0, 0);
    chk("t4_drop_end", 32'(err_drop), 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_req", 32'(req), 32'd0);
    // T5 grant lost mid-packet
    ov_log.delete();
    cyc(1, fl(3'b001, 4), 0);
    cyc(1, fl(3'b010, 1), 0);
    cyc(1, fl(3'b010, 2), 0);
    cyc(1, fl(3'b100, 3), 0);
    repeat (3) cyc(0, '0, 1);
    repeat (3) cyc(0, '0, 0);
    chk("t5_req_held", 32'(req), 32'd1);
    chk("t5_count", 32'(count), 32'd2);
    chk("t5_ov", 32'(out_valid), 32'd0);
    repeat (2) cyc(0, '0, 1);
    chk("t5_done", 32'(count), 32'd0);
    chk("t5_req", 32'(req), 32'd0);
    chk("t5_nout", 32'(ov_log.size()), 32'd4);
    // T6 async reset mid-transfer
    for (int i = 0; i < 6; i++) cyc(1, i == 0 ? fl(3'b001, 5) : fl(3'b010, i), 0);
    repeat (2) cyc(0, '0, 1);
    grant = 1'b0;
    chk("t6_pre_count", 32'(count), 32'd5);
    chk("t6_pre_req", 32'(req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_rdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) cyc(0, '0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
